// File: rtl/demux51_seq.sv
// ---------------------------------------------------------------------------
// demux51_seq
//
// Registered 1-to-5 demultiplexer. This is the receiving end of the 5:1 select
// tree. A serial data bit is steered onto one of five lane flops, either by an
// explicit 3-bit select (direct mode) or by an internal scan counter (scan
// mode). In scan mode five consecutive valid bits are reassembled into a word.
// Each finished word is handed downstream with a one-cycle valid strobe.
//
// Ports:
//   clk        in   1  single clock, rising edge
//   rst        in   1  synchronous, active-high reset
//   din        in   1  serial data bit
//   din_valid  in   1  qualifies din; nothing changes while low
//   mode       in   1  0 = direct select, 1 = scan (auto-index)
//   s          in   3  lane select, direct mode only (1xx all map to lane 4)
//   y          out  5  lane register, bit k = last bit routed to lane k
//   idx        out  3  current scan position, 0..4
//   word       out  5  last completed scan word, bit k = bit taken at index k
//   word_valid out  1  one-cycle pulse whenever word is updated
// ---------------------------------------------------------------------------
module demux51_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       mode,
  input  logic [2:0] s,
  output logic [4:0] y,
  output logic [2:0] idx,
  output logic       word_valid,
  output logic [4:0] word
);

  // The previous-mode register is kept as a two-state enum. A mode change is
  // simply "the mode input differs from the registered mode".
  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  localparam logic [2:0] LAST_IDX = 3'd4;

  mode_e      mode_q,       mode_d;
  logic [4:0] y_q,          y_d;
  logic [2:0] idx_q,        idx_d;
  logic [4:0] word_q,       word_d;
  logic       word_valid_q, word_valid_d;

  logic       mode_change;
  logic [2:0] lane;
  logic [2:0] scan_pos;

  // Lane decode mirrors the mux select tree: 000..011 pick lanes 0..3 and
  // any select with the top bit set lands on lane 4, so no value is illegal.
  always_comb begin
    lane = 3'd0;
    if (s[2]) begin
      lane = 3'd4;
    end else begin
      lane = {1'b0, s[1:0]};
    end
  end

  // Mode bookkeeping and the effective scan position. On a mode change the
  // partial frame is thrown away, so the bit arriving this cycle (if any) is
  // treated as index 0. The same applies if the counter somehow sits at an
  // unreachable value 5..7, which keeps the frame alignment self-healing.
  always_comb begin
    mode_d      = mode ? MODE_SCAN : MODE_DIRECT;
    mode_change = (mode_d != mode_q);
    scan_pos    = idx_q;
    if (mode_change || (idx_q > LAST_IDX)) begin
      scan_pos = 3'd0;
    end
  end

  // Next-state logic for the datapath. Everything holds by default and the
  // word strobe drops by default. That makes it a single-cycle pulse even when
  // din_valid stays high straight into the next frame. Only a valid bit moves
  // the lanes or the counter. A mode change on its own just rewinds idx and
  // leaves word untouched.
  always_comb begin
    y_d          = y_q;
    idx_d        = idx_q;
    word_d       = word_q;
    word_valid_d = 1'b0;

    if (mode_change) begin
      idx_d = 3'd0;
    end

    if (din_valid) begin
      if (mode_d == MODE_DIRECT) begin
        y_d[lane] = din;
      end else begin
        y_d[scan_pos] = din;
        if (scan_pos == LAST_IDX) begin
          // Lanes 0..3 still hold this frame's earlier bits, and the 5th bit
          // comes straight from din, so the word is ready on the same edge.
          word_d       = {din, y_q[3:0]};
          word_valid_d = 1'b1;
          idx_d        = 3'd0;
        end else begin
          idx_d = scan_pos + 3'd1;
        end
      end
    end
  end

  // State register. Reset wins over everything, including a valid bit and a
  // mode change. A frame in progress is dropped silently, with no strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= MODE_DIRECT;
      y_q          <= 5'd0;
      idx_q        <= 3'd0;
      word_q       <= 5'd0;
      word_valid_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      y_q          <= y_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign y          = y_q;
  assign idx        = idx_q;
  assign word       = word_q;
  assign word_valid = word_valid_q;

endmodule

// File: tb/tb_demux51_seq.sv
// ---------------------------------------------------------------------------
// tb_demux51_seq
//
// Directed, table-driven bench for demux51_seq. Each table record holds one
// clock's inputs and the register values expected after that edge. A short
// hand-written back-to-back sequence follows, which checks the strobe spacing
// across two consecutive frames.
// ---------------------------------------------------------------------------
module tb_demux51_seq;

  logic       clk;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       mode;
  logic [2:0] s;
  logic [4:0] y;
  logic [2:0] idx;
  logic [4:0] word;
  logic       word_valid;

  int vectors;
  int miscompares;

  typedef struct {
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       mode;
    logic [2:0] s;
    logic [4:0] exp_y;
    logic [2:0] exp_idx;
    logic [4:0] exp_word;
    logic       exp_wv;
  } vec_t;

  vec_t table_q[$];

  demux51_seq dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .mode       (mode),
    .s          (s),
    .y          (y),
    .idx        (idx),
    .word       (word),
    .word_valid (word_valid)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Appends one record to the vector table.
  function automatic void addVec(input logic r, input logic d, input logic v,
                                 input logic m, input logic [2:0] sel,
                                 input logic [4:0] ey, input logic [2:0] ei,
                                 input logic [4:0] ew, input logic ewv);
    vec_t t;
    t.rst = r;   t.din = d;    t.din_valid = v; t.mode = m; t.s = sel;
    t.exp_y = ey; t.exp_idx = ei; t.exp_word = ew; t.exp_wv = ewv;
    table_q.push_back(t);
  endfunction

  // Drives one cycle of inputs, then waits for the edge plus 1 ns.
  task automatic applyStimulus(input logic r, input logic d, input logic v,
                               input logic m, input logic [2:0] sel);
    rst = r; din = d; din_valid = v; mode = m; s = sel;
    @(posedge clk);
    #1;
  endtask

  // Compares every output against the expected values for one vector.
  task automatic checkOutput(input string name, input logic [4:0] ey,
                             input logic [2:0] ei, input logic [4:0] ew,
                             input logic ewv);
    vectors++;
    if (y !== ey) begin
      miscompares++;
      $display("[TB] FAIL %s y: got %b, want %b", name, y, ey);
    end
    if (idx !== ei) begin
      miscompares++;
      $display("[TB] FAIL %s idx: got %0d, want %0d", name, idx, ei);
    end
    if (word !== ew) begin
      miscompares++;
      $display("[TB] FAIL %s word: got %b, want %b", name, word, ew);
    end
    if (word_valid !== ewv) begin
      miscompares++;
      $display("[TB] FAIL %s word_valid: got %b, want %b", name, word_valid, ewv);
    end
  endtask

  initial begin
    logic [9:0] bits;
    logic [4:0] exp_word_hold;
    logic [4:0] exp_y_run;

    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; mode = 1'b0; s = 3'd0;

    //      rst din vld mode s      y         idx   word      wv
    // Reset held for two cycles while a valid 1 is offered.
    addVec(1, 1, 1, 0, 3'd0, 5'b00000, 3'd0, 5'b00000, 0);
    addVec(1, 1, 1, 0, 3'd0, 5'b00000, 3'd0, 5'b00000, 0);
    // Direct mode: walk all selects, then clear lane 2, then an idle cycle.
    addVec(0, 1, 1, 0, 3'd0, 5'b00001, 3'd0, 5'b00000, 0);
    addVec(0, 1, 1, 0, 3'd1, 5'b00011, 3'd0, 5'b00000, 0);
    addVec(0, 1, 1, 0, 3'd2, 5'b00111, 3'd0, 5'b00000, 0);
    addVec(0, 1, 1, 0, 3'd3, 5'b01111, 3'd0, 5'b00000, 0);
    addVec(0, 1, 1, 0, 3'd4, 5'b11111, 3'd0, 5'b00000, 0);
    addVec(0, 1, 1, 0, 3'd5, 5'b11111, 3'd0, 5'b00000, 0);
    addVec(0, 1, 1, 0, 3'd6, 5'b11111, 3'd0, 5'b00000, 0);
    addVec(0, 1, 1, 0, 3'd7, 5'b11111, 3'd0, 5'b00000, 0);
    addVec(0, 0, 1, 0, 3'd2, 5'b11011, 3'd0, 5'b00000, 0);
    addVec(0, 0, 0, 0, 3'd0, 5'b11011, 3'd0, 5'b00000, 0);
    // Lane 4 only, via s=110 with din=0.
    addVec(0, 0, 1, 0, 3'd6, 5'b01011, 3'd0, 5'b00000, 0);
    // Scan frame 1,0,1,1,0 back to back.
    addVec(1, 0, 0, 0, 3'd0, 5'b00000, 3'd0, 5'b00000, 0);
    addVec(0, 1, 1, 1, 3'd0, 5'b00001, 3'd1, 5'b00000, 0);
    addVec(0, 0, 1, 1, 3'd0, 5'b00001, 3'd2, 5'b00000, 0);
    addVec(0, 1, 1, 1, 3'd0, 5'b00101, 3'd3, 5'b00000, 0);
    addVec(0, 1, 1, 1, 3'd0, 5'b01101, 3'd4, 5'b00000, 0);
    addVec(0, 0, 1, 1, 3'd0, 5'b01101, 3'd0, 5'b01101, 1);
    addVec(0, 0, 0, 1, 3'd0, 5'b01101, 3'd0, 5'b01101, 0);
    // Same frame with gaps; idx holds while din_valid is low.
    addVec(1, 0, 0, 0, 3'd0, 5'b00000, 3'd0, 5'b00000, 0);
    addVec(0, 1, 1, 1, 3'd0, 5'b00001, 3'd1, 5'b00000, 0);
    addVec(0, 1, 0, 1, 3'd0, 5'b00001, 3'd1, 5'b00000, 0);
    addVec(0, 0, 1, 1, 3'd0, 5'b00001, 3'd2, 5'b00000, 0);
    addVec(0, 0, 0, 1, 3'd0, 5'b00001, 3'd2, 5'b00000, 0);
    addVec(0, 1, 1, 1, 3'd0, 5'b00101, 3'd3, 5'b00000, 0);
    addVec(0, 0, 0, 1, 3'd0, 5'b00101, 3'd3, 5'b00000, 0);
    addVec(0, 1, 1, 1, 3'd0, 5'b01101, 3'd4, 5'b00000, 0);
    addVec(0, 1, 0, 1, 3'd0, 5'b01101, 3'd4, 5'b00000, 0);
    addVec(0, 0, 1, 1, 3'd0, 5'b01101, 3'd0, 5'b01101, 1);
    addVec(0, 0, 0, 1, 3'd0, 5'b01101, 3'd0, 5'b01101, 0);
    // Abort: three bits, one cycle in direct mode, back to scan, full frame.
    addVec(0, 1, 1, 1, 3'd0, 5'b01101, 3'd1, 5'b01101, 0);
    addVec(0, 1, 1, 1, 3'd0, 5'b01111, 3'd2, 5'b01101, 0);
    addVec(0, 1, 1, 1, 3'd0, 5'b01111, 3'd3, 5'b01101, 0);
    addVec(0, 0, 0, 0, 3'd0, 5'b01111, 3'd0, 5'b01101, 0);
    addVec(0, 0, 0, 1, 3'd0, 5'b01111, 3'd0, 5'b01101, 0);
    addVec(0, 1, 1, 1, 3'd0, 5'b01111, 3'd1, 5'b01101, 0);
    addVec(0, 1, 1, 1, 3'd0, 5'b01111, 3'd2, 5'b01101, 0);
    addVec(0, 1, 1, 1, 3'd0, 5'b01111, 3'd3, 5'b01101, 0);
    addVec(0, 1, 1, 1, 3'd0, 5'b01111, 3'd4, 5'b01101, 0);
    addVec(0, 1, 1, 1, 3'd0, 5'b11111, 3'd0, 5'b11111, 1);
    addVec(0, 1, 0, 1, 3'd0, 5'b11111, 3'd0, 5'b11111, 0);
    // Mode change with a valid bit: the bit takes the new mode, at index 0.
    addVec(0, 0, 1, 1, 3'd0, 5'b11110, 3'd1, 5'b11111, 0);
    addVec(0, 0, 1, 1, 3'd0, 5'b11100, 3'd2, 5'b11111, 0);
    addVec(0, 0, 1, 0, 3'd4, 5'b01100, 3'd0, 5'b11111, 0);
    addVec(0, 1, 1, 1, 3'd0, 5'b01101, 3'd1, 5'b11111, 0);
    // Reset mid-frame, with valid data and a mode change pending.
    addVec(0, 1, 1, 1, 3'd0, 5'b01111, 3'd2, 5'b11111, 0);
    addVec(0, 1, 1, 1, 3'd0, 5'b01111, 3'd3, 5'b11111, 0);
    addVec(1, 1, 1, 1, 3'd0, 5'b00000, 3'd0, 5'b00000, 0);
    addVec(0, 0, 1, 1, 3'd0, 5'b00000, 3'd1, 5'b00000, 0);
    addVec(0, 0, 1, 1, 3'd0, 5'b00000, 3'd2, 5'b00000, 0);
    addVec(0, 0, 1, 1, 3'd0, 5'b00000, 3'd3, 5'b00000, 0);
    addVec(0, 0, 1, 1, 3'd0, 5'b00000, 3'd4, 5'b00000, 0);
    addVec(0, 1, 1, 1, 3'd0, 5'b10000, 3'd0, 5'b10000, 1);
    addVec(0, 0, 0, 1, 3'd0, 5'b10000, 3'd0, 5'b10000, 0);

    $display("[TB] applying %0d table vectors", table_q.size());
    foreach (table_q[i]) begin
      applyStimulus(table_q[i].rst, table_q[i].din, table_q[i].din_valid,
                    table_q[i].mode, table_q[i].s);
      checkOutput($sformatf("vec%0d", i), table_q[i].exp_y, table_q[i].exp_idx,
                  table_q[i].exp_word, table_q[i].exp_wv);
    end

    // Back-to-back frames: ten valid bits with no gap. The strobe must fire
    // after the 5th and the 10th edges only. Scan mode is already registered,
    // and idx is at 0 and y is 10000 from the last table entry.
    bits          = 10'b11010_10011;
    exp_word_hold = 5'b10000;
    exp_y_run     = 5'b10000;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, bits[i], 1'b1, 1'b1, 3'd0);
      exp_y_run[i % 5] = bits[i];
      if (i % 5 == 4) exp_word_hold = exp_y_run;
      checkOutput($sformatf("b2b%0d", i), exp_y_run, 3'((i + 1) % 5),
                  exp_word_hold, (i % 5 == 4));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    checkOutput("b2b_idle", 5'b11010, 3'd0, 5'b11010, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
